systolic_tile_feeder: RTL and testbench

Upstream stage of the 2x2 output-stationary systolic array. It accepts one 2x2 A tile and one 2x2 B tile over a valid/ready handshake and buffers them. It then drives the array's row and column edges with the diagonally skewed operand stream, pulses the accumulator clear beforehand, and signals tile completion after a programmable drain. Every PE(i,j) ends holding C[i][j] = sum over k of A[i][k]*B[k][j].

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/tile_skew_sel.sv | 36 +++
 rtl/systolic_tile_feeder.sv | 164 ++++++++++++++++
 tb/tb_systolic_tile_feeder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared definitions for the 2x2 systolic tile feeder.
//   DIM        array dimension (tiles are DIM x DIM)
//   FEED_STEPS number of skewed feed steps per tile (2*DIM-1)
//   state_t    feeder FSM state encoding
//   elem_idx   flat element index of tile element [row][col]
package systolic_pkg;

    localparam int DIM        = 2;
    localparam int FEED_STEPS = 2*DIM - 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

    function automatic int elem_idx(input int row, input int col);
        return row*DIM + col;
    endfunction

endpackage

// File: rtl/tile_skew_sel.sv
// tile_skew_sel: combinational selection of the diagonally skewed array edge
// operands for one feed step.
// Ports:
//   a_tile  in   buffered A tile, A[i][k] at (i*DIM+k)*DATA_W
//   b_tile  in   buffered B tile, B[k][j] at (k*DIM+j)*DATA_W
//   step    in   feed step t
//   a_edge  out  row-edge operands, row i = A[i][t-i] or 0
//   b_edge  out  column-edge operands, column j = B[t-j][j] or 0
module tile_skew_sel
    import systolic_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DIM*DIM*DATA_W-1:0] a_tile,
    input  logic [DIM*DIM*DATA_W-1:0] b_tile,
    input  logic [3:0]                step,
    output logic [DIM*DATA_W-1:0]     a_edge,
    output logic [DIM*DATA_W-1:0]     b_edge
);

    // Edge r carries the element whose inner index k satisfies t == r + k;
    // for rows that is A[r][k], for columns it is B[k][r].
    always_comb begin
        a_edge = '0;
        b_edge = '0;
        for (int r = 0; r < DIM; r++) begin
            for (int k = 0; k < DIM; k++) begin
                if (step == 4'(r + k)) begin
                    a_edge[r*DATA_W +: DATA_W] = a_tile[elem_idx(r, k)*DATA_W +: DATA_W];
                    b_edge[r*DATA_W +: DATA_W] = b_tile[elem_idx(k, r)*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_tile_feeder.sv
// systolic_tile_feeder: accepts a 2x2 A/B tile pair, clears the PE
// accumulators, streams the skewed operands into the array edges, waits a
// programmable drain and pulses tile_done.
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   in_valid     tile pair offered
//   in_ready     feeder can accept a tile pair (combinational)
//   a_mat,b_mat  A / B tiles, element [r][c] at (2*r+c)*DATA_W
//   a_out,b_out  row / column edge operands (registered)
//   feed_valid   a_out/b_out carry a feed step
//   pe_clr       clear the PE accumulators
//   busy         tile in flight
//   tile_done    one-cycle pulse, results final in the array
// Optional feature: define SYSTOLIC_FEEDER_PREFETCH_EN to add a one-entry
// shadow buffer so the next tile can be accepted while the current one runs.
//
// state | meaning
// IDLE  | waiting for a tile pair
// CLEAR | pe_clr asserted for one cycle
// FEED  | FEED_STEPS skewed operand steps
// DRAIN | DRAIN_CYCLES zero-feed cycles while the array finishes
// DONE  | tile_done pulse; promote a prefetched tile if present
module systolic_tile_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DATA_W-1:0] a_mat,
    input  logic [4*DATA_W-1:0] b_mat,
    output logic [2*DATA_W-1:0] a_out,
    output logic [2*DATA_W-1:0] b_out,
    output logic                feed_valid,
    output logic                pe_clr,
    output logic                busy,
    output logic                tile_done
);

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          step_cnt;
    logic [3:0]          step_nxt;
    logic [3:0]          drain_cnt;
    logic [3:0]          drain_nxt;
    logic [4*DATA_W-1:0] a_buf;
    logic [4*DATA_W-1:0] b_buf;
    logic [2*DATA_W-1:0] a_skew;
    logic [2*DATA_W-1:0] b_skew;
    logic                accept;

`ifdef SYSTOLIC_FEEDER_PREFETCH_EN
    logic [4*DATA_W-1:0] a_shd;
    logic [4*DATA_W-1:0] b_shd;
    logic                shd_full;

    assign in_ready = !rst && (state == IDLE || !shd_full);
`else
    assign in_ready = !rst && (state == IDLE);
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = CLEAR;
            CLEAR: state_nxt = FEED;
            FEED:  if (step_cnt == 4'(FEED_STEPS - 1)) state_nxt = DRAIN;
            DRAIN: if (drain_cnt == 4'(DRAIN_CYCLES - 1)) state_nxt = DONE;
`ifdef SYSTOLIC_FEEDER_PREFETCH_EN
            // Either a prefetched tile or one arriving right now restarts
            // the sequence without passing through IDLE.
            DONE:  state_nxt = (shd_full || accept) ? CLEAR : IDLE;
`else
            DONE:  state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase

        step_nxt  = (state == FEED  && state_nxt == FEED)  ? step_cnt  + 4'd1 : 4'd0;
        drain_nxt = (state == DRAIN && state_nxt == DRAIN) ? drain_cnt + 4'd1 : 4'd0;
    end

    // Selected with the step of the coming cycle so the edge registers
    // present step t exactly while the FSM sits in FEED step t.
    tile_skew_sel #(
        .DATA_W (DATA_W)
    ) u_skew (
        .a_tile (a_buf),
        .b_tile (b_buf),
        .step   (step_nxt),
        .a_edge (a_skew),
        .b_edge (b_skew)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            step_cnt   <= '0;
            drain_cnt  <= '0;
            a_out      <= '0;
            b_out      <= '0;
            feed_valid <= 1'b0;
            pe_clr     <= 1'b0;
            busy       <= 1'b0;
            tile_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            step_cnt   <= step_nxt;
            drain_cnt  <= drain_nxt;
            a_out      <= (state_nxt == FEED) ? a_skew : '0;
            b_out      <= (state_nxt == FEED) ? b_skew : '0;
            feed_valid <= (state_nxt == FEED);
            pe_clr     <= (state_nxt == CLEAR);
            busy       <= (state_nxt != IDLE);
            tile_done  <= (state_nxt == DONE);
        end
    end

`ifdef SYSTOLIC_FEEDER_PREFETCH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_buf    <= '0;
            b_buf    <= '0;
            a_shd    <= '0;
            b_shd    <= '0;
            shd_full <= 1'b0;
        end else begin
            if (state == DONE && shd_full) begin
                a_buf    <= a_shd;
                b_buf    <= b_shd;
                shd_full <= 1'b0;
            end
            // Later assignments win: a tile arriving during promotion lands
            // in the shadow slot just freed.
            if (accept) begin
                if (state == IDLE || (state == DONE && !shd_full)) begin
                    a_buf <= a_mat;
                    b_buf <= b_mat;
                end else begin
                    a_shd    <= a_mat;
                    b_shd    <= b_mat;
                    shd_full <= 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_buf <= '0;
            b_buf <= '0;
        end else if (accept) begin
            a_buf <= a_mat;
            b_buf <= b_mat;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_tile_feeder.sv
module tb_systolic_tile_feeder;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
    } feed_t;

    typedef struct {
        logic [63:0] c00;
        logic [63:0] c01;
        logic [63:0] c10;
        logic [63:0] c11;
    } res_t;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        in_valid  [2];
    logic [63:0] a_mat;
    logic [63:0] b_mat;
    logic        rdy       [2];
    logic [31:0] a_o       [2];
    logic [31:0] b_o       [2];
    logic        fv        [2];
    logic        clr       [2];
    logic        bsy       [2];
    logic        done      [2];

    int    cyc  = 0;
    int    nchk = 0;
    int    nerr = 0;
    int    last_done [2];
    feed_t q_feed [2][$];
    int    q_clr  [2][$];
    int    q_done [2][$];
    res_t  q_c [$];

    logic [15:0]     ah [2];
    logic [15:0]     bv [2];
    longint unsigned acc00, acc01, acc10, acc11;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_tile_feeder #(.DATA_W(16), .DRAIN_CYCLES(2)) u_d2 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(rdy[0]),
        .a_mat(a_mat), .b_mat(b_mat), .a_out(a_o[0]), .b_out(b_o[0]),
        .feed_valid(fv[0]), .pe_clr(clr[0]), .busy(bsy[0]), .tile_done(done[0])
    );

    systolic_tile_feeder #(.DATA_W(16), .DRAIN_CYCLES(5)) u_d5 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(rdy[1]),
        .a_mat(a_mat), .b_mat(b_mat), .a_out(a_o[1]), .b_out(b_o[1]),
        .feed_valid(fv[1]), .pe_clr(clr[1]), .busy(bsy[1]), .tile_done(done[1])
    );

    function automatic int drain_of(input int d);
        return (d == 0) ? 2 : 5;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic unexpected(input string nm, input int d);
        nchk++;
        nerr++;
        $display("FAIL %s: dut%0d produced it with nothing expected, required none (cycle %0d)", nm, d, cyc + 1);
    endtask

    // Hand-derived skew: t=0 -> rows {0,A00} cols {0,B00};
    // t=1 -> rows {A10,A01} cols {B01,B10}; t=2 -> rows {A11,0} cols {B11,0}.
    task automatic exp_step(input logic [63:0] a, input logic [63:0] b, input int t,
                            output logic [31:0] ae, output logic [31:0] be);
        case (t)
            0:       begin ae = {16'h0, a[15:0]};     be = {16'h0, b[15:0]};     end
            1:       begin ae = {a[47:32], a[31:16]}; be = {b[31:16], b[47:32]}; end
            default: begin ae = {a[63:48], 16'h0};    be = {b[63:48], 16'h0};    end
        endcase
    endtask

    function automatic res_t matmul(input logic [63:0] a, input logic [63:0] b);
        res_t r;
        r.c00 = 64'(a[15:0])  * 64'(b[15:0])  + 64'(a[31:16]) * 64'(b[47:32]);
        r.c01 = 64'(a[15:0])  * 64'(b[31:16]) + 64'(a[31:16]) * 64'(b[63:48]);
        r.c10 = 64'(a[47:32]) * 64'(b[15:0])  + 64'(a[63:48]) * 64'(b[47:32]);
        r.c11 = 64'(a[47:32]) * 64'(b[31:16]) + 64'(a[63:48]) * 64'(b[63:48]);
        return r;
    endfunction

    // Offer a tile at a negedge; on acceptance push the full expected schedule.
    // A tile accepted while the previous one is in flight starts after that
    // tile's tile_done cycle.
    task automatic send_tile(input int d, input logic [63:0] a, input logic [63:0] b, input bit hold);
        int    w;
        int    t_acc;
        int    s;
        feed_t f;
        in_valid[d] = 1'b1;
        a_mat = a;
        b_mat = b;
        w = 0;
        while (!rdy[d] && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!rdy[d]) begin
            nchk++;
            nerr++;
            $display("FAIL accept_timeout: dut%0d in_ready stayed 0, required 1", d);
            in_valid[d] = 1'b0;
            return;
        end
        t_acc = cyc + 1;
        s = (t_acc > last_done[d]) ? t_acc : last_done[d];
        q_clr[d].push_back(s + 1);
        for (int t = 0; t < 3; t++) begin
            f.cyc = s + 2 + t;
            exp_step(a, b, t, f.a, f.b);
            q_feed[d].push_back(f);
        end
        last_done[d] = s + 5 + drain_of(d);
        q_done[d].push_back(last_done[d]);
        if (d == 0) q_c.push_back(matmul(a, b));
        @(posedge clk);
        @(negedge clk);
        if (!hold) in_valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int w;
        w = 0;
        while ((q_done[d].size() != 0 || bsy[d]) && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (q_done[d].size() != 0 || bsy[d]) begin
            nchk++;
            nerr++;
            $display("FAIL idle_timeout: dut%0d still busy, %0d tile_done pending, required idle", d, q_done[d].size());
        end
        @(negedge clk);
    endtask

    // 2x2 output-stationary array driven by dut0 edges.
    always @(posedge clk) begin
        if (clr[0]) begin
            acc00 <= 0; acc01 <= 0; acc10 <= 0; acc11 <= 0;
        end else begin
            acc00 <= acc00 + 64'(a_o[0][15:0])  * 64'(b_o[0][15:0]);
            acc01 <= acc01 + 64'(ah[0])         * 64'(b_o[0][31:16]);
            acc10 <= acc10 + 64'(a_o[0][31:16]) * 64'(bv[0]);
            acc11 <= acc11 + 64'(ah[1])         * 64'(bv[1]);
        end
        ah[0] <= a_o[0][15:0];
        ah[1] <= a_o[0][31:16];
        bv[0] <= b_o[0][15:0];
        bv[1] <= b_o[0][31:16];
    end

    // Monitor: outputs are sampled at the negedge and belong to cycle cyc+1.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (fv[d]) begin
                if (q_feed[d].size() == 0) unexpected("feed_valid", d);
                else begin
                    feed_t f;
                    f = q_feed[d].pop_front();
                    chk($sformatf("feed_cycle_d%0d", d), 64'(cyc + 1), 64'(f.cyc));
                    chk($sformatf("a_out_d%0d", d), 64'(a_o[d]), 64'(f.a));
                    chk($sformatf("b_out_d%0d", d), 64'(b_o[d]), 64'(f.b));
                end
            end else begin
                chk($sformatf("idle_edges_zero_d%0d", d), {a_o[d], b_o[d]}, 64'h0);
            end
            if (clr[d]) begin
                if (q_clr[d].size() == 0) unexpected("pe_clr", d);
                else chk($sformatf("pe_clr_cycle_d%0d", d), 64'(cyc + 1), 64'(q_clr[d].pop_front()));
            end
            if (done[d]) begin
                if (q_done[d].size() == 0) unexpected("tile_done", d);
                else begin
                    chk($sformatf("tile_done_cycle_d%0d", d), 64'(cyc + 1), 64'(q_done[d].pop_front()));
                    if (d == 0 && q_c.size() != 0) begin
                        res_t r;
                        r = q_c.pop_front();
                        chk("c00", acc00, r.c00);
                        chk("c01", acc01, r.c01);
                        chk("c10", acc10, r.c10);
                        chk("c11", acc11, r.c11);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ta, tb;
        rst[0] = 1'b1; rst[1] = 1'b1;
        in_valid[0] = 1'b0; in_valid[1] = 1'b0;
        a_mat = '0; b_mat = '0;
        last_done[0] = 0; last_done[1] = 0;
        repeat (2) @(negedge clk);
        in_valid[0] = 1'b1;
        #1;
        chk("rst_in_ready", 64'(rdy[0]), 64'h0);
        chk("rst_ctl", 64'({fv[0], clr[0], bsy[0], done[0]}), 64'h0);
        chk("rst_edges", {a_o[0], b_o[0]}, 64'h0);
        in_valid[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        #1;
        chk("ready_after_rst", 64'(rdy[0]), 64'h1);
        @(negedge clk);

        // A=[[1,2],[3,4]] B=[[5,6],[7,8]] -> C = 19,22,43,50
        ta = {16'd4, 16'd3, 16'd2, 16'd1};
        tb = {16'd8, 16'd7, 16'd6, 16'd5};
        send_tile(0, ta, tb, 1'b0);
        wait_idle(0);

`ifndef SYSTOLIC_FEEDER_PREFETCH_EN
        // Back-pressure: valid held high with changing data while busy.
        send_tile(0, {16'h0011, 16'h0022, 16'h0033, 16'h0044},
                     {16'h0101, 16'h0202, 16'h0303, 16'h0404}, 1'b1);
        for (int i = 0; i < 7; i++) begin
            chk("bp_in_ready", 64'(rdy[0]), 64'h0);
            a_mat = {$urandom, $urandom};
            b_mat = {$urandom, $urandom};
            if (i == 6) in_valid[0] = 1'b0;
            else @(negedge clk);
        end
        wait_idle(0);
`endif

        // All-ones operands: no truncation or sign extension.
        send_tile(0, {4{16'hFFFF}}, {4{16'hFFFF}}, 1'b0);
        wait_idle(0);

        send_tile(0, {16'hABCD, 16'h0000, 16'h0000, 16'h1234},
                     {16'h0002, 16'h8000, 16'h0007, 16'h0003}, 1'b0);
        wait_idle(0);

        // Five drain cycles on the second instance.
        send_tile(1, ta, tb, 1'b0);
        wait_idle(1);

`ifdef SYSTOLIC_FEEDER_PREFETCH_EN
        send_tile(0, ta, tb, 1'b0);
        repeat (2) @(negedge clk);
        send_tile(0, {16'd9, 16'd10, 16'd11, 16'd12}, {16'd2, 16'd3, 16'd4, 16'd5}, 1'b0);
        in_valid[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pf_in_ready", 64'(rdy[0]), 64'h0);
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        wait_idle(0);
`endif

        // Reset while step t=1 is on the edges: tile discarded, no tile_done.
        send_tile(0, ta, tb, 1'b0);
        repeat (2) @(negedge clk);
        #2;
        rst[0] = 1'b1;
        #1;
        chk("midrst_ctl", 64'({rdy[0], fv[0], clr[0], bsy[0], done[0]}), 64'h0);
        chk("midrst_edges", {a_o[0], b_o[0]}, 64'h0);
        q_feed[0].delete();
        q_clr[0].delete();
        q_done[0].delete();
        q_c.delete();
        last_done[0] = 0;
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        #1;
        chk("post_rst_ready", 64'(rdy[0]), 64'h1);
        chk("post_rst_busy", 64'(bsy[0]), 64'h0);
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
